// File: rtl/aes_dec_out_serializer_pkg.sv
// Shared types and helpers for the AES decrypt output serializer.
package aes_dec_out_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Words per block.
  function automatic int unsigned calc_wpb(input int unsigned block_length,
                                           input int unsigned word_width);
    return block_length / word_width;
  endfunction

  // Counter width that stays legal when only one value is needed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO between the decryption core and the word serializer.
module aes_blk_fifo #(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [BLOCK_LENGTH-1:0]       data_i,
  output logic [BLOCK_LENGTH-1:0]       head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BLOCK_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage is intentionally left unreset; a reset write is discarded.
  always_ff @(posedge clk) begin
    if (push_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/aes_dec_out_serializer.sv
// Buffers decrypted blocks and streams them out MSW-first with ready/valid.
module aes_dec_out_serializer
  import aes_dec_out_serializer_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BLOCK_LENGTH-1:0]     blk_in,
  input  logic                        blk_valid,
  output logic [WORD_WIDTH-1:0]       word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        word_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        overflow
);

  localparam int unsigned WPB   = calc_wpb(BLOCK_LENGTH, WORD_WIDTH);
  localparam int unsigned WC_W  = cnt_width(WPB);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ser_state_e              state_q, state_d;
  logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
  logic                    overflow_q, overflow_d;
  logic [BLOCK_LENGTH-1:0] head, head_shifted;
  logic [CNT_W-1:0]        count;
  logic                    full, push, pop, hs, at_last;

  assign hs      = word_valid && word_ready;
  assign at_last = (word_cnt_q == WC_W'(WPB - 1));
  assign pop     = hs && at_last;
  // A full FIFO still accepts a block when the head leaves in the same cycle.
  assign push    = blk_valid && (!full || pop);

  aes_blk_fifo #(
    .BLOCK_LENGTH (BLOCK_LENGTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (blk_in),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q | (blk_valid && full && !pop);
    if (hs) word_cnt_d = at_last ? '0 : word_cnt_q + WC_W'(1);
    case (state_q)
      ST_IDLE: if (push) state_d = ST_SEND;
      ST_SEND: if (pop && !push && (count == CNT_W'(1))) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign head_shifted = head << (int'(word_cnt_q) * WORD_WIDTH);

  always_comb begin
    word_valid = (state_q == ST_SEND);
    word_last  = word_valid && at_last;
    word_out   = word_valid ? head_shifted[BLOCK_LENGTH-1 -: WORD_WIDTH] : '0;
    fifo_count = count;
    fifo_full  = full;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_aes_dec_out_serializer.sv
// Randomized and directed checks of the serializer against a queue-based model.
module tb_aes_dec_out_serializer;

  localparam int unsigned BL  = 128;
  localparam int unsigned WW  = 32;
  localparam int unsigned FD  = 4;
  localparam int unsigned WPB = BL / WW;

  logic          clk, rst, blk_valid, word_ready;
  logic [BL-1:0] blk_in;
  logic [WW-1:0] word_out;
  logic          word_valid, word_last, fifo_full, overflow;
  logic [2:0]    fifo_count;

  aes_dec_out_serializer #(
    .BLOCK_LENGTH (BL),
    .WORD_WIDTH   (WW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: a queue of whole blocks and the index of the word on offer.
  logic [BL-1:0] mq [$];
  int            mk   = 0;
  bit            movf = 1'b0;

  logic [WW-1:0] obs_word;
  logic          obs_valid, obs_last, obs_full, obs_ovf;
  logic [2:0]    obs_count;

  task automatic chk(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [WW-1:0] word_of(input logic [BL-1:0] b, input int k);
    logic [BL-1:0] t;
    t = b << (k * WW);
    return t[BL-1 -: WW];
  endfunction

  // One clock: drive inputs, compare outputs to model mid-cycle, then advance model.
  task automatic cycle(input bit r, input bit bv, input logic [BL-1:0] b, input bit rd);
    bit v, l, pp;
    rst = r; blk_valid = bv; blk_in = b; word_ready = rd;
    @(negedge clk);
    v = (mq.size() != 0);
    l = v && (mk == WPB - 1);
    obs_word = word_out; obs_valid = word_valid; obs_last = word_last;
    obs_count = fifo_count; obs_full = fifo_full; obs_ovf = overflow;
    chk("valid", BL'(obs_valid), BL'(v));
    chk("word",  BL'(obs_word),  v ? BL'(word_of(mq[0], mk)) : '0);
    chk("last",  BL'(obs_last),  BL'(l));
    chk("count", BL'(obs_count), BL'(mq.size()));
    chk("full",  BL'(obs_full),  BL'(mq.size() == FD));
    chk("ovf",   BL'(obs_ovf),   BL'(movf));
    @(posedge clk);
    if (r) begin
      mq.delete(); mk = 0; movf = 1'b0;
    end else begin
      pp = v && rd && l;
      if (v && rd) mk = l ? 0 : mk + 1;
      if (pp) void'(mq.pop_front());
      if (bv) begin
        if (mq.size() < FD) mq.push_back(b);
        else movf = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [BL-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [BL-1:0] blks [6];
  logic [WW-1:0] exp_w [4];
  logic [BL-1:0] kat;

  initial begin
    rst = 1'b1; blk_valid = 1'b0; blk_in = '0; word_ready = 1'b0;
    kat = 128'h00112233445566778899aabbccddeeff;
    exp_w[0] = 32'h00112233; exp_w[1] = 32'h44556677;
    exp_w[2] = 32'h8899aabb; exp_w[3] = 32'hccddeeff;

    // Reset state
    cycle(1, 0, '0, 0);
    cycle(1, 1, rnd_blk(), 1);
    cycle(0, 0, '0, 1);
    chk("rst_count", BL'(obs_count), '0);
    chk("rst_valid", BL'(obs_valid), '0);

    // Known block, ready always high
    cycle(0, 1, kat, 1);
    chk("kat_lat0", BL'(obs_valid), '0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, '0, 1);
      chk($sformatf("kat_w%0d", k), BL'(obs_word), BL'(exp_w[k]));
      chk($sformatf("kat_last%0d", k), BL'(obs_last), BL'(k == 3));
    end
    cycle(0, 0, '0, 1);
    chk("kat_done", BL'(obs_valid), '0);

    // Backpressure on word 1
    cycle(0, 1, kat, 1);
    cycle(0, 0, '0, 1);
    chk("bp_w0", BL'(obs_word), BL'(exp_w[0]));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, 0);
      chk($sformatf("bp_hold%0d", i), BL'(obs_word), BL'(exp_w[1]));
      chk($sformatf("bp_vld%0d", i), BL'(obs_valid), 1);
    end
    for (int k = 1; k < 4; k++) begin
      cycle(0, 0, '0, 1);
      chk($sformatf("bp_w%0d", k), BL'(obs_word), BL'(exp_w[k]));
    end

    // Overflow: five blocks while stalled
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      blks[i] = rnd_blk();
      cycle(0, 1, blks[i], 0);
    end
    cycle(0, 0, '0, 0);
    chk("ovf_count", BL'(obs_count), BL'(FD));
    chk("ovf_full",  BL'(obs_full), 1);
    chk("ovf_flag",  BL'(obs_ovf), 1);
    for (int j = 0; j < 16; j++) begin
      cycle(0, 0, '0, 1);
      chk($sformatf("ovf_drain%0d", j), BL'(obs_word), BL'(word_of(blks[j / 4], j % 4)));
    end
    cycle(0, 0, '0, 1);
    chk("ovf_blk5_absent", BL'(obs_valid), '0);
    chk("ovf_sticky", BL'(obs_ovf), 1);

    // Push and pop together while full
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, rnd_blk(), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
    cycle(0, 1, rnd_blk(), 1);
    chk("pp_last", BL'(obs_last), 1);
    cycle(0, 0, '0, 0);
    chk("pp_count", BL'(obs_count), BL'(FD));
    chk("pp_ovf",   BL'(obs_ovf), '0);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

    // Reset in the middle of a block
    cycle(1, 0, '0, 0);
    cycle(0, 1, kat, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    cycle(1, 1, rnd_blk(), 1);
    cycle(0, 0, '0, 1);
    chk("mid_rst_valid", BL'(obs_valid), '0);
    chk("mid_rst_count", BL'(obs_count), '0);
    chk("mid_rst_ovf",   BL'(obs_ovf), '0);
    cycle(0, 1, kat, 1);
    cycle(0, 0, '0, 1);
    chk("mid_rst_fresh_w0", BL'(obs_word), BL'(exp_w[0]));
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

    // Continuous streaming, one block every four cycles
    cycle(0, 1, rnd_blk(), 1);
    for (int i = 1; i <= 40; i++) begin
      cycle(0, (i % 4) == 0, rnd_blk(), 1);
      chk($sformatf("stream_gapless%0d", i), BL'(obs_valid), 1);
      chk($sformatf("stream_cnt%0d", i), BL'(obs_count > 3'd1), '0);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 4, rnd_blk(),
            $urandom_range(0, 9) < 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
